snes_frame_sync_ctrl: RTL and testbench
=======================================

Name: snes_frame_sync_ctrl

Overview:
- Clk-domain controller that sequences per-frame SNES/HDMI alignment.
- Lets the SNES core run about 0.5% fast, then halts it on a chosen line during DRAM refresh until the HDMI frame start arrives from the pixel domain.
- Releases the pause only after an even number of cycles, so PPU SDRAM slots stay aligned.
- Adds timeout recovery, a lock indicator and optional statistics; drives pause_snes_for_frame_sync for the video/audio converter.

Parameters:
- SYNC_LINE, 2: SNES line (ys[7:0]) on which the pause may start.
- REARM_LINE, 200: SNES line that re-arms sync for the next frame.
- TIMEOUT, 400000: max pause length in clk cycles before forced release; must be even.
- TO_W, 19: width of the pause cycle counter; must satisfy 2^TO_W > TIMEOUT.
- LOCK_FRAMES, 4: consecutive clean syncs needed to assert locked.

Ports:
- clk, in, 1: SNES clock.
- resetn, in, 1: reset, synchronous, active-low; clock clk.
- enable, in, 1: frame sync enabled; 0 = free-run.
- ys, in, 8: current SNES line number.
- snes_refresh, in, 1: SNES DRAM refresh window active.
- hdmi_frame_tgl, in, 1: pixel-domain toggle, flips once per HDMI frame at the first active line.
- pause, out, 1: pause_snes_for_frame_sync.
- sync_done, out, 1: this frame already synced.
- locked, out, 1: LOCK_FRAMES consecutive syncs without timeout.
- timeout_pulse, out, 1: one-cycle pulse on a forced release.
- pause_cycles, out, TO_W: length of the last completed pause (stats).
- timeout_count, out, 8: saturating count of timeouts (stats).

Behaviour:
- Reset (resetn=0 at a clk edge): all outputs are 0, state is RUN, the synchronizer is loaded with the current sampled value so no spurious edge is produced. A pause in progress drops on the next edge.
- CDC:
  - hdmi_frame_tgl passes through a 2-FF synchronizer plus a 3rd flop.
  - hdmi_edge = ff2 ^ ff3, so there are 3 clk cycles of latency.
  - The input must hold at least 3 clk cycles between toggles.
- States RUN, PAUSE, DONE:
  - RUN: pause=0, sync_done=0. If enable && ys==SYNC_LINE && snes_refresh, then next state is PAUSE and cnt is set to 1 (pause goes high on that edge).
  - PAUSE: pause=1, cnt increments each cycle. pend is set by hdmi_edge (a same-cycle edge counts).
    - Normal exit: (pend||hdmi_edge) && cnt[0]==0. Go to DONE, with the pause total equal to cnt (always even, at least 2).
    - Timeout: cnt==TIMEOUT. Go to DONE, timeout_pulse=1, locked cleared, lock counter reset.
    - enable falling: exit at the next even cnt and go to RUN (not DONE).
  - DONE: pause=0, sync_done=1. ys==REARM_LINE goes to RUN; pend is cleared.
- hdmi_edge in RUN or DONE is discarded; pend is only live in PAUSE.
- Lock: each non-timeout exit increments the lock counter, saturating at LOCK_FRAMES; locked=1 when it equals LOCK_FRAMES. enable=0 clears locked.
- SYNC_LINE == REARM_LINE is illegal (elaboration assertion).
- snes_refresh is sampled only in RUN on SYNC_LINE; if it is not seen, the frame is skipped until REARM.

Optional Feature:
- Macro FRAME_SYNC_STATS_EN.
- With the macro defined:
  - pause_cycles latches cnt on every PAUSE exit.
  - timeout_count increments on timeout_pulse and saturates at 255.
- Without it: both outputs are tied to 0 and the registers are removed. Core behaviour is unchanged.

Decomposition:
- Package snes_video_pkg:
  - sync_state_t enum {RUN, PAUSE, DONE}.
  - Constants SNES_ACTIVE_LINES=224 and HDMI_FIRST_LINE=24.
- Sub-module toggle_sync: 2-FF synchronizer plus edge detect. Reusable for other pixel-to-clk events.

Test Plan:
1. Reset, enable=1, ys=2 with snes_refresh=1 for one cycle -> pause rises on the next edge. Toggle hdmi_frame_tgl 10 cycles later -> pause falls after an even total near 14 cycles; sync_done=1; pause_cycles equals the high time.
2. hdmi toggle arriving while cnt is odd -> release delayed one cycle; pause high time is even in 100 randomized trials.
3. No hdmi toggle, TIMEOUT=64 -> pause high exactly 64 cycles, timeout_pulse for 1 cycle, locked=0, timeout_count=1.
4. Four consecutive frames, hdmi toggle 50 cycles into each pause -> locked rises after the 4th exit. A 5th frame with a timeout -> locked drops.
5. hdmi toggle during RUN at ys=100, then PAUSE entered at ys=2 -> the stale edge is ignored and pause holds until a new toggle.
6. resetn=0 mid-PAUSE (cnt=37) -> pause=0 on the next edge; after release the state is RUN with no spurious edge. enable=0 mid-pause -> release at the next even cnt, state RUN, sync_done=0.

Source files
------------

// File: rtl/snes_video_pkg.sv
// Shared SNES video timing types and constants.
// Used by the frame sync controller and related video blocks.
package snes_video_pkg;

    typedef enum logic [1:0] {
        RUN,
        PAUSE,
        DONE
    } sync_state_t;

    localparam int SNES_ACTIVE_LINES = 224;
    localparam int HDMI_FIRST_LINE   = 24;

endpackage

// File: rtl/toggle_sync.sv
// Two-flop synchronizer plus edge detect for a toggle crossing into clk.
// Reset loads the chain with the sampled input so no edge is produced.
module toggle_sync (
    input  logic clk,
    input  logic resetn,
    input  logic tgl,
    output logic pulse
);

    logic ff1;
    logic ff2;
    logic ff3;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ff1 <= tgl;
            ff2 <= ff1;
            ff3 <= ff1;
        end else begin
            ff1 <= tgl;
            ff2 <= ff1;
            ff3 <= ff2;
        end
    end

    assign pulse = ff2 ^ ff3;

endmodule

// File: rtl/snes_frame_sync_ctrl.sv
// Halts the SNES on a chosen line until the HDMI frame start arrives.
// Optional stats under FRAME_SYNC_STATS_EN (pause length, timeout count).
module snes_frame_sync_ctrl
    import snes_video_pkg::*;
#(
    parameter int SYNC_LINE   = 2,
    parameter int REARM_LINE  = 200,
    parameter int TIMEOUT     = 400000,
    parameter int TO_W        = 19,
    parameter int LOCK_FRAMES = 4
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            enable,
    input  logic [7:0]      ys,
    input  logic            snes_refresh,
    input  logic            hdmi_frame_tgl,
    output logic            pause,
    output logic            sync_done,
    output logic            locked,
    output logic            timeout_pulse,
    output logic [TO_W-1:0] pause_cycles,
    output logic [7:0]      timeout_count
);

    localparam int LW = $clog2(LOCK_FRAMES + 1);

    localparam logic [7:0]      SYNC_Y  = SYNC_LINE[7:0];
    localparam logic [7:0]      REARM_Y = REARM_LINE[7:0];
    localparam logic [TO_W-1:0] TO_VAL  = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0] ONE     = TO_W'(1);
    localparam logic [LW-1:0]   LOCK_N  = LW'(LOCK_FRAMES);
    localparam logic [LW-1:0]   LOCK_N1 = LW'(LOCK_FRAMES - 1);

    if (SYNC_LINE == REARM_LINE) begin : g_bad_lines
        $error("SYNC_LINE must differ from REARM_LINE");
    end
    if ((TIMEOUT % 2) != 0) begin : g_bad_timeout
        $error("TIMEOUT must be even");
    end
    if (TIMEOUT >= (2 ** TO_W)) begin : g_bad_width
        $error("TO_W too narrow for TIMEOUT");
    end

    sync_state_t     state;
    logic [TO_W-1:0] cnt;
    logic            pend;
    logic [LW-1:0]   lock_cnt;
    logic            hdmi_edge;

    logic in_pause;
    logic ev;
    logic got_frame;
    logic stop_exit;
    logic sync_exit;
    logic to_exit;

    toggle_sync u_tsync (
        .clk    (clk),
        .resetn (resetn),
        .tgl    (hdmi_frame_tgl),
        .pulse  (hdmi_edge)
    );

    // Exits only on even counts keep the PPU SDRAM slot phase intact.
    assign in_pause  = (state == PAUSE);
    assign ev        = in_pause & ~cnt[0];
    assign got_frame = pend | hdmi_edge;
    assign stop_exit = ev & ~enable;
    assign sync_exit = ev & enable & got_frame;
    assign to_exit   = in_pause & enable & ~got_frame & (cnt == TO_VAL);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= RUN;
            cnt           <= '0;
            pend          <= 1'b0;
            pause         <= 1'b0;
            sync_done     <= 1'b0;
            locked        <= 1'b0;
            lock_cnt      <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            timeout_pulse <= 1'b0;
            unique case (state)
                RUN: begin
                    if (enable && ys == SYNC_Y && snes_refresh) begin
                        state <= PAUSE;
                        cnt   <= ONE;
                        pend  <= 1'b0;
                        pause <= 1'b1;
                    end
                end
                PAUSE: begin
                    cnt <= cnt + ONE;
                    if (hdmi_edge)
                        pend <= 1'b1;
                    unique case (1'b1)
                        stop_exit: begin
                            state <= RUN;
                            pause <= 1'b0;
                        end
                        sync_exit: begin
                            state     <= DONE;
                            pause     <= 1'b0;
                            sync_done <= 1'b1;
                            locked    <= (lock_cnt >= LOCK_N1);
                            if (lock_cnt != LOCK_N)
                                lock_cnt <= lock_cnt + LW'(1);
                        end
                        to_exit: begin
                            state         <= DONE;
                            pause         <= 1'b0;
                            sync_done     <= 1'b1;
                            timeout_pulse <= 1'b1;
                            locked        <= 1'b0;
                            lock_cnt      <= '0;
                        end
                        default: ;
                    endcase
                end
                DONE: begin
                    if (ys == REARM_Y) begin
                        state     <= RUN;
                        sync_done <= 1'b0;
                        pend      <= 1'b0;
                    end
                end
                default: state <= RUN;
            endcase
            if (!enable) begin
                locked   <= 1'b0;
                lock_cnt <= '0;
            end
        end
    end

`ifdef FRAME_SYNC_STATS_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pause_cycles  <= '0;
            timeout_count <= '0;
        end else begin
            if (stop_exit | sync_exit | to_exit)
                pause_cycles <= cnt;
            if (to_exit && timeout_count != 8'hFF)
                timeout_count <= timeout_count + 8'd1;
        end
    end
`else
    assign pause_cycles  = '0;
    assign timeout_count = '0;
`endif

endmodule

// File: tb/tb_snes_frame_sync_ctrl.sv
// Directed bench for snes_frame_sync_ctrl with a short TIMEOUT.
// Expected pause lengths are hand-derived from the toggle timing.
module tb_snes_frame_sync_ctrl;

    localparam int TO_W = 8;

`ifdef FRAME_SYNC_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            resetn;
    logic            enable;
    logic [7:0]      ys;
    logic            snes_refresh;
    logic            hdmi_frame_tgl;
    logic            pause;
    logic            sync_done;
    logic            locked;
    logic            timeout_pulse;
    logic [TO_W-1:0] pause_cycles;
    logic [7:0]      timeout_count;

    int tests = 0;
    int fails = 0;

    snes_frame_sync_ctrl #(
        .SYNC_LINE   (2),
        .REARM_LINE  (200),
        .TIMEOUT     (64),
        .TO_W        (TO_W),
        .LOCK_FRAMES (4)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .enable         (enable),
        .ys             (ys),
        .snes_refresh   (snes_refresh),
        .hdmi_frame_tgl (hdmi_frame_tgl),
        .pause          (pause),
        .sync_done      (sync_done),
        .locked         (locked),
        .timeout_pulse  (timeout_pulse),
        .pause_cycles   (pause_cycles),
        .timeout_count  (timeout_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got,
                         input longint exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rearm();
        ys = 8'd200;
        step();
        ys = 8'd0;
        step();
    endtask

    // Enter a pause and count its high cycles; tog_at/den_at are
    // loop indices at which to toggle hdmi or drop enable (-1 = never).
    task automatic frame(input int tog_at, input int den_at,
                         output int hi, output bit to);
        ys = 8'd2;
        snes_refresh = 1'b1;
        step();
        ys = 8'd50;
        snes_refresh = 1'b0;
        hi = 0;
        to = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!pause) begin
                to = timeout_pulse;
                break;
            end
            hi++;
            if (i == tog_at)
                hdmi_frame_tgl = ~hdmi_frame_tgl;
            if (i == den_at)
                enable = 1'b0;
            step();
        end
    endtask

    initial begin
        int hi;
        bit to;
        int t;

        resetn = 1'b0;
        enable = 1'b1;
        ys = 8'd0;
        snes_refresh = 1'b0;
        hdmi_frame_tgl = 1'b0;
        repeat (3) step();
        resetn = 1'b1;
        step();
        check("rst_pause", pause, 0);
        check("rst_done", sync_done, 0);
        check("rst_locked", locked, 0);
        check("rst_to_pulse", timeout_pulse, 0);
        check("rst_pcyc", pause_cycles, 0);
        check("rst_tocnt", timeout_count, 0);

        // Toggle 10 cycles into the pause
        frame(10, -1, hi, to);
        check("t1_high", hi, 14);
        check("t1_to", to, 0);
        check("t1_done", sync_done, 1);
        check("t1_pcyc", pause_cycles, STATS ? 14 : 0);
        rearm();
        check("t1_rearm", sync_done, 0);

        // Random toggle phase: release always on an even count
        for (int k = 0; k < 100; k++) begin
            t = int'($urandom_range(0, 40));
            frame(t, -1, hi, to);
            check("t2_high", hi, (t + 4) & ~1);
            check("t2_even", hi % 2, 0);
            rearm();
        end
        check("t2_locked", locked, 1);

        // No toggle: timeout
        frame(-1, -1, hi, to);
        check("t3_high", hi, 64);
        check("t3_pulse", to, 1);
        check("t3_locked", locked, 0);
        step();
        check("t3_pulse_1cyc", timeout_pulse, 0);
        check("t3_tocnt", timeout_count, STATS ? 1 : 0);
        check("t3_pcyc", pause_cycles, STATS ? 64 : 0);
        rearm();

        // Lock after four clean syncs, lost on a timeout
        for (int k = 0; k < 4; k++) begin
            frame(47, -1, hi, to);
            check("t4_high", hi, 50);
            check("t4_locked", locked, (k == 3) ? 1 : 0);
            rearm();
        end
        frame(-1, -1, hi, to);
        check("t4_to", to, 1);
        check("t4_unlock", locked, 0);
        step();
        check("t4_tocnt", timeout_count, STATS ? 2 : 0);
        rearm();

        // Stale edge during RUN must be ignored
        ys = 8'd100;
        hdmi_frame_tgl = ~hdmi_frame_tgl;
        repeat (6) step();
        frame(30, -1, hi, to);
        check("t5_high", hi, 34);
        rearm();

        // Reset at cnt=37, toggle input while in reset
        ys = 8'd2;
        snes_refresh = 1'b1;
        step();
        ys = 8'd50;
        snes_refresh = 1'b0;
        repeat (36) step();
        check("t6_in_pause", pause, 1);
        resetn = 1'b0;
        hdmi_frame_tgl = ~hdmi_frame_tgl;
        step();
        check("t6_rst_pause", pause, 0);
        check("t6_rst_locked", locked, 0);
        repeat (2) step();
        resetn = 1'b1;
        step();
        frame(20, -1, hi, to);
        check("t6_no_spur", hi, 24);
        rearm();

        // enable drop at cnt=21 releases at 22 into RUN
        frame(-1, 20, hi, to);
        check("t6_en_high", hi, 22);
        check("t6_en_to", to, 0);
        check("t6_en_done", sync_done, 0);
        check("t6_en_locked", locked, 0);
        check("t6_en_pcyc", pause_cycles, STATS ? 22 : 0);
        enable = 1'b1;
        ys = 8'd2;
        snes_refresh = 1'b1;
        step();
        check("t6_en_run", pause, 1);
        ys = 8'd50;
        snes_refresh = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
